// File: rtl/pwm_output_stage_pkg.sv
// Shared register map, bit positions and per-channel configuration type for the PWM block.
// The register store and I2C target import the same package.
package pwm_output_stage_pkg;

    localparam int CNT_W          = 12;
    localparam int REG_COUNT      = 256;
    localparam int MODE1_ADDR     = 8'h00;
    localparam int MODE2_ADDR     = 8'h01;
    localparam int LED0_ON_L_ADDR = 8'h06;
    localparam int LED_STRIDE     = 4;
    localparam int SLEEP_BIT      = 4;
    localparam int INVRT_BIT      = 4;
    localparam int FULL_BIT       = 4;

    typedef struct packed {
        logic             full_on;
        logic             full_off;
        logic [CNT_W-1:0] on_cnt;
        logic [CNT_W-1:0] off_cnt;
    } led_cfg_t;

    // Reset shadow is forced full-off so outputs sit at the inactive level until the first wrap.
    localparam led_cfg_t LED_CFG_RESET = '{full_on: 1'b0, full_off: 1'b1,
                                           on_cnt: '0, off_cnt: '0};

    function automatic led_cfg_t decode_led(input logic [7:0] on_l, input logic [7:0] on_h,
                                            input logic [7:0] off_l, input logic [7:0] off_h);
        led_cfg_t cfg;
        cfg.full_on  = on_h[FULL_BIT];
        cfg.full_off = off_h[FULL_BIT];
        cfg.on_cnt   = {on_h[3:0], on_l};
        cfg.off_cnt  = {off_h[3:0], off_l};
        return cfg;
    endfunction

endpackage

// File: rtl/pwm_output_stage_channel.sv
// One PWM channel: period-aligned shadow of its settings, ON/OFF window compare and output flop.
// Shadow loads only on the wrap clock so mid-period register writes take effect next period.
module pwm_channel
    import pwm_output_stage_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wrap,
    input  led_cfg_t         live_cfg,
    input  logic [CNT_W-1:0] counter,
    input  logic             invrt,
    input  logic             sleep,
    output logic             pwm
);

    led_cfg_t shadow_q;
    led_cfg_t eff_cfg;
    logic     raw_level;
    logic     active_level;

    always_comb begin
        eff_cfg   = wrap ? live_cfg : shadow_q;
        raw_level = 1'b0;
        if (eff_cfg.full_off) begin
            raw_level = 1'b0;
        end else if (eff_cfg.full_on) begin
            raw_level = 1'b1;
        end else if (eff_cfg.on_cnt < eff_cfg.off_cnt) begin
            raw_level = (counter >= eff_cfg.on_cnt) && (counter < eff_cfg.off_cnt);
        end else if (eff_cfg.on_cnt > eff_cfg.off_cnt) begin
            raw_level = (counter >= eff_cfg.on_cnt) || (counter < eff_cfg.off_cnt);
        end
        active_level = sleep ? invrt : (raw_level ^ invrt);
    end

    // compare -> registered output
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            shadow_q <= LED_CFG_RESET;
            pwm      <= 1'b0;
        end else begin
            if (wrap) begin
                shadow_q <= live_cfg;
            end
            pwm <= active_level;
        end
    end

endmodule

// File: rtl/pwm_output_stage.sv
// PWM output stage: wrap detection on the shared period counter, live global controls,
// and NUM_CHANNELS pwm_channel instances fed from the register image.
module pwm_output_stage
    import pwm_output_stage_pkg::*;
#(
    parameter int NUM_CHANNELS = 16
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic [0:2047]           register_blob_i,
    input  logic [CNT_W-1:0]        counter_i,
    output logic [NUM_CHANNELS-1:0] pwm_o,
    output logic                    period_start_o
);

    logic [CNT_W-1:0] counter_q;
    logic             wrap;
    logic [7:0]       mode1;
    logic [7:0]       mode2;
    logic             sleep;
    logic             invrt;
    logic             unused_blob;

    assign mode1 = register_blob_i[8*MODE1_ADDR +: 8];
    assign mode2 = register_blob_i[8*MODE2_ADDR +: 8];
    assign sleep = mode1[SLEEP_BIT];
    assign invrt = mode2[INVRT_BIT];

    // A jump to zero from any non-zero value is a wrap; holding at zero is not.
    assign wrap = (counter_i == '0) && (counter_q != '0);

    assign unused_blob = ^register_blob_i;

    // wrap detect -> period_start_o
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            counter_q      <= '0;
            period_start_o <= 1'b0;
        end else begin
            counter_q      <= counter_i;
            period_start_o <= wrap;
        end
    end

    for (genvar n = 0; n < NUM_CHANNELS; n++) begin : g_ch
        localparam int BASE = 8 * (LED0_ON_L_ADDR + LED_STRIDE * n);
        led_cfg_t live_cfg;

        assign live_cfg = decode_led(register_blob_i[BASE      +: 8],
                                     register_blob_i[BASE + 8  +: 8],
                                     register_blob_i[BASE + 16 +: 8],
                                     register_blob_i[BASE + 24 +: 8]);

        pwm_channel u_ch (
            .clk      (clk_i),
            .rst_n    (rst_ni),
            .wrap     (wrap),
            .live_cfg (live_cfg),
            .counter  (counter_i),
            .invrt    (invrt),
            .sleep    (sleep),
            .pwm      (pwm_o[n])
        );
    end

endmodule

// File: tb/tb_pwm_output_stage.sv
// Testbench for pwm_output_stage: constant vector table, hand-written corner sequences and
// randomized traffic checked against a behavioural model of the period/shadow rules.
module tb_pwm_output_stage;

    localparam int NCH = 16;

    logic            clk = 1'b0;
    logic            rst_ni;
    logic [0:2047]   blob;
    logic [11:0]     counter;
    logic [NCH-1:0]  pwm;
    logic            ps;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pwm_output_stage #(.NUM_CHANNELS(NCH)) dut (
        .clk_i           (clk),
        .rst_ni          (rst_ni),
        .register_blob_i (blob),
        .counter_i       (counter),
        .pwm_o           (pwm),
        .period_start_o  (ps)
    );

    typedef struct {
        bit fon;
        bit foff;
        int on;
        int off;
    } mcfg_t;

    typedef struct {
        int on;
        int off;
        bit fon;
        bit foff;
        bit invrt;
        bit sleep;
        int cnt;
        bit exp;
    } vec_t;

    mcfg_t          m_shadow [NCH];
    int             m_cq;
    logic [NCH-1:0] exp_pwm;
    logic           exp_ps;

    function automatic logic [7:0] rd(input int a);
        return blob[8*a +: 8];
    endfunction

    function automatic mcfg_t live(input int ch);
        mcfg_t c;
        int    b;
        b      = 6 + 4 * ch;
        c.on   = int'(rd(b + 1) & 8'h0F) * 256 + int'(rd(b));
        c.off  = int'(rd(b + 3) & 8'h0F) * 256 + int'(rd(b + 2));
        c.fon  = (rd(b + 1) & 8'h10) != 0;
        c.foff = (rd(b + 3) & 8'h10) != 0;
        return c;
    endfunction

    function automatic bit level(input mcfg_t c, input int cnt);
        if (c.foff) return 1'b0;
        if (c.fon) return 1'b1;
        if (c.on < c.off) return (cnt >= c.on) && (cnt < c.off);
        if (c.on > c.off) return (cnt >= c.on) || (cnt < c.off);
        return 1'b0;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h (counter=%h t=%0t)", name, act, req, counter, $time);
        end
    endtask

    task automatic set_reg(input int a, input logic [7:0] v);
        blob[8*a +: 8] = v;
    endtask

    task automatic set_led(input int ch, input int on, input int off, input bit fon, input bit foff);
        int b;
        b = 6 + 4 * ch;
        set_reg(b,     8'(on & 255));
        set_reg(b + 1, 8'((on >> 8) & 15) | (fon ? 8'h10 : 8'h00));
        set_reg(b + 2, 8'(off & 255));
        set_reg(b + 3, 8'((off >> 8) & 15) | (foff ? 8'h10 : 8'h00));
    endtask

    // Advance one clock: predict from the inputs present at the edge, then compare.
    task automatic tick();
        logic [NCH-1:0] e;
        logic [7:0]     m1, m2;
        bit             w, inv, slp;
        mcfg_t          eff;
        e = '0;
        if (!rst_ni) begin
            exp_pwm = '0;
            exp_ps  = 1'b0;
            m_cq    = 0;
            for (int ch = 0; ch < NCH; ch++) m_shadow[ch] = '{fon: 1'b0, foff: 1'b1, on: 0, off: 0};
        end else begin
            m1  = rd(0);
            m2  = rd(1);
            slp = m1[4];
            inv = m2[4];
            w   = (counter == 12'd0) && (m_cq != 0);
            for (int ch = 0; ch < NCH; ch++) begin
                eff   = w ? live(ch) : m_shadow[ch];
                e[ch] = slp ? inv : (level(eff, int'(counter)) ^ inv);
                if (w) m_shadow[ch] = live(ch);
            end
            exp_pwm = e;
            exp_ps  = w;
            m_cq    = int'(counter);
        end
        @(posedge clk);
        #1;
        check("pwm_o", 64'(pwm), 64'(exp_pwm));
        check("period_start_o", 64'(ps), 64'(exp_ps));
    endtask

    task automatic force_wrap();
        counter = 12'd1;
        tick();
        counter = 12'd0;
        tick();
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl [17];
        int   ps_count;
        int   r;
        int   ch;

        tbl[0]  = '{on: 'h199, off: 'h4CC, fon: 0, foff: 0, invrt: 0, sleep: 0, cnt: 'h199, exp: 1};
        tbl[1]  = '{on: 'h199, off: 'h4CC, fon: 0, foff: 0, invrt: 0, sleep: 0, cnt: 'h198, exp: 0};
        tbl[2]  = '{on: 'h199, off: 'h4CC, fon: 0, foff: 0, invrt: 0, sleep: 0, cnt: 'h4CB, exp: 1};
        tbl[3]  = '{on: 'h199, off: 'h4CC, fon: 0, foff: 0, invrt: 0, sleep: 0, cnt: 'h4CC, exp: 0};
        tbl[4]  = '{on: 'hE00, off: 'h100, fon: 0, foff: 0, invrt: 0, sleep: 0, cnt: 'hFFF, exp: 1};
        tbl[5]  = '{on: 'hE00, off: 'h100, fon: 0, foff: 0, invrt: 0, sleep: 0, cnt: 'h0FF, exp: 1};
        tbl[6]  = '{on: 'hE00, off: 'h100, fon: 0, foff: 0, invrt: 0, sleep: 0, cnt: 'h100, exp: 0};
        tbl[7]  = '{on: 'hE00, off: 'h100, fon: 0, foff: 0, invrt: 0, sleep: 0, cnt: 'h800, exp: 0};
        tbl[8]  = '{on: 'h800, off: 'h800, fon: 0, foff: 0, invrt: 0, sleep: 0, cnt: 'h800, exp: 0};
        tbl[9]  = '{on: 'h000, off: 'h000, fon: 1, foff: 0, invrt: 0, sleep: 0, cnt: 'h000, exp: 1};
        tbl[10] = '{on: 'h000, off: 'h000, fon: 1, foff: 1, invrt: 0, sleep: 0, cnt: 'h000, exp: 0};
        tbl[11] = '{on: 'h000, off: 'hFFF, fon: 0, foff: 0, invrt: 0, sleep: 0, cnt: 'hFFE, exp: 1};
        tbl[12] = '{on: 'h000, off: 'hFFF, fon: 0, foff: 0, invrt: 0, sleep: 0, cnt: 'hFFF, exp: 0};
        tbl[13] = '{on: 'h199, off: 'h4CC, fon: 0, foff: 0, invrt: 1, sleep: 0, cnt: 'h200, exp: 0};
        tbl[14] = '{on: 'h199, off: 'h4CC, fon: 0, foff: 0, invrt: 1, sleep: 0, cnt: 'h100, exp: 1};
        tbl[15] = '{on: 'h000, off: 'h000, fon: 1, foff: 0, invrt: 0, sleep: 1, cnt: 'h005, exp: 0};
        tbl[16] = '{on: 'h000, off: 'h000, fon: 0, foff: 0, invrt: 1, sleep: 1, cnt: 'h005, exp: 1};

        rst_ni  = 1'b0;
        blob    = '0;
        counter = 12'd0;
        m_cq    = 0;
        tick();
        tick();
        check("reset_pwm", 64'(pwm), 64'd0);
        check("reset_period_start", 64'(ps), 64'd0);

        // INVRT during reset: flops clear to 0, then inactive level is 1 until first wrap.
        set_reg(1, 8'h10);
        tick();
        check("reset_pwm_invrt", 64'(pwm), 64'd0);
        rst_ni = 1'b1;
        counter = 12'd5;
        tick();
        check("post_reset_inactive_invrt", 64'(pwm), 64'hFFFF);
        set_reg(1, 8'h00);
        rst_ni = 1'b0;
        counter = 12'd0;
        tick();
        rst_ni = 1'b1;

        // All LED registers zero: outputs stay low, one period_start per wrap.
        ps_count = 0;
        for (int c = 0; c < 4096; c++) begin
            counter = 12'(c);
            tick();
            if (ps) ps_count++;
        end
        counter = 12'd0;
        tick();
        if (ps) ps_count++;
        tick();
        if (ps) ps_count++;
        check("sweep_pwm_low", 64'(pwm), 64'd0);
        check("sweep_wrap_pulses", 64'(ps_count), 64'd1);

        // Table of single-point vectors on channel 0.
        for (int i = 0; i < 17; i++) begin
            set_led(0, tbl[i].on, tbl[i].off, tbl[i].fon, tbl[i].foff);
            set_reg(0, tbl[i].sleep ? 8'h10 : 8'h00);
            set_reg(1, tbl[i].invrt ? 8'h10 : 8'h00);
            force_wrap();
            counter = 12'(tbl[i].cnt);
            tick();
            check($sformatf("tbl[%0d]_pwm0", i), 64'(pwm[0]), 64'(tbl[i].exp));
        end
        blob = '0;

        // Mid-period OFF change on channel 2 only takes effect next period.
        set_led(2, 0, 'h400, 0, 0);
        force_wrap();
        for (int c = 1; c < 4096; c++) begin
            if (c == 'h300) set_led(2, 0, 'h200, 0, 0);
            counter = 12'(c);
            tick();
            if (c == 'h3FF) check("ch2_old_off_high", 64'(pwm[2]), 64'd1);
            if (c == 'h400) check("ch2_old_off_low", 64'(pwm[2]), 64'd0);
        end
        counter = 12'd0;
        tick();
        check("ch2_wrap_period_start", 64'(ps), 64'd1);
        for (int c = 1; c <= 'h200; c++) begin
            counter = 12'(c);
            tick();
            if (c == 'h1FF) check("ch2_new_off_high", 64'(pwm[2]), 64'd1);
            if (c == 'h200) check("ch2_new_off_low", 64'(pwm[2]), 64'd0);
        end
        blob = '0;

        // Channel 3 full flags, then live INVRT and SLEEP.
        set_led(3, 0, 0, 1, 1);
        force_wrap();
        counter = 12'h010;
        tick();
        check("ch3_full_both_low", 64'(pwm[3]), 64'd0);
        set_led(3, 0, 0, 1, 0);
        counter = 12'h011;
        tick();
        check("ch3_cleared_off_held", 64'(pwm[3]), 64'd0);
        counter = 12'd0;
        tick();
        check("ch3_full_on_after_wrap", 64'(pwm[3]), 64'd1);
        set_reg(1, 8'h10);
        counter = 12'd1;
        tick();
        check("invrt_all", 64'(pwm), 64'hFFF7);
        set_reg(0, 8'h10);
        counter = 12'd2;
        tick();
        check("sleep_invrt", 64'(pwm), 64'hFFFF);
        set_reg(1, 8'h00);
        counter = 12'd3;
        tick();
        check("sleep_no_invrt", 64'(pwm), 64'h0000);
        blob = '0;

        // Reset mid-period discards the active shadow.
        set_led(0, 'h100, 'hF00, 0, 0);
        force_wrap();
        counter = 12'h700;
        tick();
        check("ch0_active_before_reset", 64'(pwm[0]), 64'd1);
        rst_ni = 1'b0;
        tick();
        check("reset_mid_period", 64'(pwm), 64'd0);
        rst_ni  = 1'b1;
        counter = 12'h701;
        tick();
        check("ch0_inactive_after_reset", 64'(pwm[0]), 64'd0);
        counter = 12'h702;
        tick();
        check("ch0_still_inactive", 64'(pwm[0]), 64'd0);
        counter = 12'd0;
        tick();
        counter = 12'h700;
        tick();
        check("ch0_active_after_wrap", 64'(pwm[0]), 64'd1);

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            r = $urandom_range(0, 99);
            if (r < 2) counter = 12'd0;
            else if (r < 4) counter = 12'($urandom_range(0, 4095));
            else counter = counter + 12'd1;
            if (r >= 4 && r < 12) begin
                ch = $urandom_range(0, NCH - 1);
                set_reg(6 + 4 * ch + $urandom_range(0, 3), 8'($urandom_range(0, 255)));
            end
            if (r == 12) set_reg($urandom_range(0, 1), 8'($urandom_range(0, 255)));
            rst_ni = (r == 13) ? 1'b0 : 1'b1;
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pwm_output_stage.md
PWM_OUTPUT_STAGE -- requirements
Module: pwm_output_stage

Interface
REQ-001 The block SHALL have parameter NUM_CHANNELS, default 16, giving the number of PWM outputs (legal 1..16; channel n uses LEDn registers).
REQ-002 The block SHALL have port clk_i  input  1  single system clock; all logic on its rising edge.
REQ-003 The block SHALL have port rst_ni  input  1  reset, synchronous, active-low.
REQ-004 The block SHALL have port register_blob_i  input  [0:2047]  256 x 8-bit register image; register r = bits [8r : 8r+7], bit 8r is the MSB.
REQ-005 The block SHALL have port counter_i  input  12  free-running prescaled period counter, 0..4095, wraps 4095->0.
REQ-006 The block SHALL have port pwm_o  output  NUM_CHANNELS  registered PWM outputs, bit n = channel n.
REQ-007 The block SHALL have port period_start_o  output  1  one-clock pulse on each detected counter wrap.

Function
REQ-008 Channel n settings SHALL come from registers 0x06+4n (ON_L), 0x07+4n (ON_H), 0x08+4n (OFF_L), 0x09+4n (OFF_H); ON = {ON_H[3:0],ON_L}, OFF = {OFF_H[3:0],OFF_L}, FULL_ON = ON_H[4], FULL_OFF = OFF_H[4].
REQ-009 Global controls: SLEEP = MODE1 (0x00) bit 4; INVRT = MODE2 (0x01) bit 4; both sampled live every clock, not shadowed.
REQ-010 Block SHALL hold counter_q, a registered copy of counter_i; wrap = (counter_i == 0) && (counter_q != 0).
REQ-011 Per channel, shadow ON/OFF/FULL_ON/FULL_OFF SHALL load from register_blob_i only on a clock where wrap is true; register writes mid-period SHALL NOT affect the current period (glitch-free update).
REQ-012 Effective settings for a clock SHALL be the live register values when wrap is true, otherwise the shadow values.
REQ-013 Raw level: FULL_OFF -> 0 (priority); else FULL_ON -> 1; else ON < OFF -> 1 iff ON <= counter_i < OFF; ON > OFF -> 1 iff counter_i >= ON or counter_i < OFF; ON == OFF -> 0.
REQ-014 Active level = raw XOR INVRT; SLEEP = 1 SHALL force active level to INVRT (output inactive).
REQ-015 pwm_o SHALL register the active level: latency exactly one clock from counter_i/control change to pwm_o.
REQ-016 period_start_o SHALL be registered wrap (asserts the clock after wrap, same edge as first pwm_o of new period).
REQ-017 A counter_i jump to 0 from any non-zero value SHALL count as a wrap; counter_i held at 0 SHALL NOT create repeated wraps.
REQ-018 Comparisons SHALL be unsigned 12-bit; ON/OFF values 0 and 4095 SHALL be handled without special-casing beyond REQ-013.
REQ-019 Registers above channel NUM_CHANNELS-1 SHALL be ignored.

Reset
REQ-020 While rst_ni = 0 at a clock edge: pwm_o <= 0, period_start_o <= 0, counter_q <= 0, every shadow <= ON=0, OFF=0, FULL_ON=0, FULL_OFF=1.
REQ-021 After reset, outputs SHALL follow shadow (full-off, so inactive level per INVRT/SLEEP) until the first wrap; reset asserted mid-period SHALL discard shadows with no partial-period output.

Structure
REQ-022 Register addresses (MODE1, MODE2, LED0_ON_L, stride 4), bit positions (SLEEP, INVRT, FULL bit 4) and counter width 12 SHALL live in a shared package/header used also by the register store and I2C target.
REQ-023 Per-channel shadow, compare and output flop SHALL be one sub-module pwm_channel, instantiated NUM_CHANNELS times; wrap detect, counter_q and global controls stay in the top of this block.

Verification
REQ-024 Reset then counter 0..4095..0 with all LED regs 0 -> pwm_o = 0 throughout; period_start_o pulses once per wrap.
REQ-025 Ch0 ON=0x199 OFF=0x4CC, run full period after a wrap -> pwm_o[0] high for counter 0x199..0x4CB (819 counts), one clock delayed.
REQ-026 Ch1 ON=0xE00 OFF=0x100 -> high for counter >= 0xE00 and < 0x100; ON=OFF=0x800 -> low all period.
REQ-027 Mid-period write of ch2 OFF from 0x400 to 0x200 at counter 0x300 -> current period ends at 0x400; next period ends at 0x200.
REQ-028 Ch3 FULL_ON=1 and FULL_OFF=1 -> low; clear FULL_OFF -> high from next wrap; set INVRT -> all outputs invert next clock; set SLEEP -> all outputs = INVRT next clock.
REQ-029 Assert rst_ni low at counter 0x700 with ch0 active -> pwm_o = 0 next clock; release -> ch0 stays inactive until next wrap.
